// File: rtl/div_pipe_elastic_pkg.sv
// Shared constants and cost helpers for the elastic restoring divider.
// Cell transistor counts feed the static `number` report of each instance.
package div_pipe_elastic_pkg;

    localparam int NUM_W    = 51;
    localparam int T_FS1    = 28;
    localparam int T_HS1    = 14;
    localparam int T_NOR2   = 4;
    localparam int T_MUX21H = 12;
    localparam int T_REGP   = 26;

    typedef logic [NUM_W-1:0] num_t;

    function automatic int depth(input int a_w, input int step);
        return a_w / step;
    endfunction

    // aq (dividend shifting out, quotient shifting in), divisor, remainder, dz, tag
    function automatic int rec_w(input int a_w, input int b_w, input int tag_w);
        return a_w + b_w + 1 + tag_w + b_w;
    endfunction

    function automatic longint step_cost(input int b_w, input int pos);
        int gated;
        gated = (pos + 1 < b_w) ? (b_w - 1 - pos) : 0;
        return longint'(b_w * T_FS1 + T_HS1 + gated * T_NOR2 + b_w * T_MUX21H);
    endfunction

    // Each record bit plus the valid bit costs one flop and one hold mux.
    function automatic longint bank_cost(input int rec);
        return longint'((rec + 1) * (T_REGP + T_MUX21H));
    endfunction

endpackage

// File: rtl/div_pipe_elastic_step.sv
// One restoring division step: shift in a dividend bit, trial-subtract, restore.
// POS is the global step index; divisor bits above it cannot fit and force q = 0.
module div_step
    import div_pipe_elastic_pkg::*;
#(
    parameter int B_W = 5,
    parameter int POS = 0
) (
    input  logic [B_W-1:0]   i_r,
    input  logic             i_bit,
    input  logic [B_W-1:0]   i_b,
    output logic [B_W-1:0]   o_r,
    output logic             o_q,
    output logic [NUM_W-1:0] number
);

    logic [B_W:0]   w_p;
    logic [B_W-1:0] w_diff;
    logic           w_ge;
    logic           w_hi_clear;

    assign w_p    = {i_r, i_bit};
    assign w_ge   = (w_p >= {1'b0, i_b});
    // p - b < b whenever it is taken, so the low B_W bits are exact.
    assign w_diff = w_p[B_W-1:0] - i_b;

    generate
        if (POS + 1 < B_W) begin : g_gate
            assign w_hi_clear = ~|i_b[B_W-1:POS+1];
        end else begin : g_nogate
            assign w_hi_clear = 1'b1;
        end
    endgenerate

    assign o_q    = w_ge & w_hi_clear;
    assign o_r    = o_q ? w_diff : w_p[B_W-1:0];
    assign number = NUM_W'(step_cost(B_W, POS));

endmodule

// File: rtl/div_pipe_elastic.sv
// Elastic pipelined restoring unsigned divider with valid/ready backpressure,
// bubble collapsing, divide-by-zero flag and a pass-through tag.
module div_pipe_elastic
    import div_pipe_elastic_pkg::*;
#(
    parameter int A_W       = 8,
    parameter int B_W       = 5,
    parameter int PIPE_STEP = 1,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             i_in_ready,
    input  logic [A_W-1:0]   i_a,
    input  logic [B_W-1:0]   i_b,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_out_valid,
    input  logic             o_out_ready,
    output logic [A_W-1:0]   o_q,
    output logic [B_W-1:0]   o_r,
    output logic             o_dz,
    output logic [TAG_W-1:0] o_tag,
    output logic [50:0]      number
);

    localparam int L     = depth(A_W, PIPE_STEP);
    localparam int REC_W = rec_w(A_W, B_W, TAG_W);

    generate
        if ((A_W % PIPE_STEP) != 0 || B_W < 2 || A_W < B_W || TAG_W < 1) begin : g_bad_params
            $error("div_pipe_elastic: illegal parameter combination");
        end
    endgenerate

    logic [L-1:0]     r_v;
    logic [L-1:0]     r_dz;
    logic [A_W-1:0]   r_aq  [L];
    logic [B_W-1:0]   r_b   [L];
    logic [B_W-1:0]   r_r   [L];
    logic [TAG_W-1:0] r_tag [L];

    logic [L-1:0]     w_adv;
    logic [L-1:0]     w_vld_s;
    logic [L-1:0]     w_dz_s;
    logic [A_W-1:0]   w_aq_s [L];
    logic [B_W-1:0]   w_b_s  [L];
    logic [B_W-1:0]   w_r_s  [L];
    logic [TAG_W-1:0] w_tag_s[L];
    logic [A_W-1:0]   w_aq_n [L];
    logic [B_W-1:0]   w_r_n  [L];
    logic [NUM_W-1:0] w_step_num [L*PIPE_STEP];
    logic [NUM_W-1:0] w_num;

    genvar k, j;
    generate
        for (k = 0; k < L; k++) begin : g_bank
            // A bank may advance if any bank at or beyond it is empty, or the sink drains.
            assign w_adv[k] = o_out_ready | ~&r_v[L-1:k];

            if (k == 0) begin : g_src_in
                assign w_vld_s[k] = i_in_valid;
                assign w_aq_s[k]  = i_a;
                assign w_b_s[k]   = i_b;
                assign w_r_s[k]   = '0;
                assign w_dz_s[k]  = (i_b == '0);
                assign w_tag_s[k] = i_tag;
            end else begin : g_src_prev
                assign w_vld_s[k] = r_v[k-1];
                assign w_aq_s[k]  = r_aq[k-1];
                assign w_b_s[k]   = r_b[k-1];
                assign w_r_s[k]   = r_r[k-1];
                assign w_dz_s[k]  = r_dz[k-1];
                assign w_tag_s[k] = r_tag[k-1];
            end

            logic [A_W-1:0] w_aq_c [PIPE_STEP+1];
            logic [B_W-1:0] w_r_c  [PIPE_STEP+1];
            assign w_aq_c[0] = w_aq_s[k];
            assign w_r_c[0]  = w_r_s[k];

            for (j = 0; j < PIPE_STEP; j++) begin : g_step
                logic w_q;
                div_step #(
                    .B_W (B_W),
                    .POS (k*PIPE_STEP + j)
                ) u_step (
                    .i_r    (w_r_c[j]),
                    .i_bit  (w_aq_c[j][A_W-1]),
                    .i_b    (w_b_s[k]),
                    .o_r    (w_r_c[j+1]),
                    .o_q    (w_q),
                    .number (w_step_num[k*PIPE_STEP + j])
                );
                assign w_aq_c[j+1] = {w_aq_c[j][A_W-2:0], w_q};
            end

            assign w_aq_n[k] = w_aq_c[PIPE_STEP];
            assign w_r_n[k]  = w_r_c[PIPE_STEP];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v  <= '0;
            r_dz <= '0;
            for (int n = 0; n < L; n++) begin
                r_aq[n]  <= '0;
                r_b[n]   <= '0;
                r_r[n]   <= '0;
                r_tag[n] <= '0;
            end
        end else begin
            for (int n = 0; n < L; n++) begin
                if (w_adv[n]) begin
                    r_v[n]   <= w_vld_s[n];
                    r_aq[n]  <= w_aq_n[n];
                    r_b[n]   <= w_b_s[n];
                    r_r[n]   <= w_r_n[n];
                    r_dz[n]  <= w_dz_s[n];
                    r_tag[n] <= w_tag_s[n];
                end
            end
        end
    end

    always_comb begin
        w_num = NUM_W'(L) * NUM_W'(bank_cost(REC_W));
        for (int n = 0; n < L*PIPE_STEP; n++) begin
            w_num = w_num + w_step_num[n];
        end
    end

    assign i_in_ready  = w_adv[0];
    assign o_out_valid = r_v[L-1];
    assign o_q         = r_aq[L-1];
    assign o_r         = r_r[L-1];
    assign o_dz        = r_dz[L-1];
    assign o_tag       = r_tag[L-1];
    assign number      = w_num;

endmodule

// File: doc/div_pipe_elastic.md
Name: div_pipe_elastic

Overview:
- Parametrised restoring unsigned divider with one pipeline register bank per group of PIPE_STEP quotient bits.
- Adds what the fixed 8/5 divider lacks: valid/ready backpressure with bubble collapsing, a divide-by-zero flag, a pass-through tag, and configurable operand widths and stage grouping.
- Sits between an operand producer and a result consumer, each of which may stall.
- Built from the team's gate-level cells; reports its transistor count on `number`.

Parameters:
- A_W, 8, dividend and quotient width; must satisfy A_W >= B_W >= 2.
- B_W, 5, divisor and remainder width.
- PIPE_STEP, 1, quotient bits resolved combinationally per register bank; A_W % PIPE_STEP == 0 is required, otherwise elaboration fails.
- TAG_W, 4, width of the user tag carried alongside each operation; minimum 1.

Ports:
- clk  in  1  clock; all flops rise-edge triggered.
- rst_n  in  1  asynchronous active-low reset.
- i_in_valid  in  1  operand presented.
- i_in_ready  out  1  operand accepted this cycle when i_in_valid && i_in_ready.
- i_a  in  A_W  dividend.
- i_b  in  B_W  divisor.
- i_tag  in  TAG_W  user tag.
- o_out_valid  out  1  result presented.
- o_out_ready  in  1  consumer takes the result when o_out_valid && o_out_ready.
- o_q  out  A_W  quotient.
- o_r  out  B_W  remainder.
- o_dz  out  1  divisor was zero.
- o_tag  out  TAG_W  tag of this result.
- number  out  51  sum of transistor counts of all instantiated cells.

Behaviour:
- Depth: L = A_W/PIPE_STEP banks. Bank k (k = 0..L-1) holds valid v[k], remaining dividend bits, divisor, partial quotient, partial remainder (B_W bits), dz and tag.
- Bank L-1 drives the outputs directly. o_out_valid = v[L-1].
- Reset: all v[k] = 0; data flops also cleared to 0. Hence o_out_valid = 0, o_q = 0, o_r = 0, o_dz = 0, o_tag = 0. Reset asserted mid-operation discards all in-flight operations. No result from before reset ever appears afterwards.
- Advance rules (bubble collapsing):
  - adv[L-1] = !v[L-1] || o_out_ready.
  - adv[k] = !v[k] || adv[k+1].
  - i_in_ready = adv[0]. The ready chain is combinational and ready never depends on i_in_valid.
- Bank loads:
  - Bank 0 loads when adv[0]; its new valid is i_in_valid && i_in_ready.
  - Bank k+1 loads from bank k when adv[k+1]; its new valid is v[k].
  - A bank that does not advance holds every bit.
- Latency: an operation accepted at edge t is presented from edge t+L-1, i.e. L cycles counted inclusively from the accept cycle.
- Throughput: one result per cycle with o_out_ready held high.
- Capacity: L operations. With o_out_ready low and the pipe full, i_in_ready = 0.
- Simultaneous accept and drain: with the pipe full and o_out_ready = 1, a new operand is accepted in the same cycle.
- Step arithmetic: each restoring step shifts the next dividend bit into the partial remainder, giving a (B_W+1)-bit value p, then computes p - b.
  - No borrow, or p[B_W] = 1: q bit = 1, remainder = (p - b)[B_W-1:0].
  - Borrow: q bit = 0, remainder = p[B_W-1:0].
  - While fewer than B_W bits have entered, the step reduces to narrower compares, as in the existing stage structure. Upper divisor bits force q = 0.
- Divide by zero: b == 0 at accept sets dz = 1 and it travels with the operation. Output is o_q = all ones, o_r = i_a[B_W-1:0], o_dz = 1. Subtract-by-zero naturally yields these values; the bench checks them explicitly.
- Output stability: while o_out_valid && !o_out_ready, o_q, o_r, o_dz and o_tag hold constant.
- number is a pure function of the parameters and is constant at run time.

Decomposition:
- Shared package constants: L, and the bank record width (A_W + B_W + 1 + TAG_W + partial fields) for the regbank instances.
- Sub-module div_step (params B_W, POS): one restoring step built from HS1/FS1 chains, NOR gating of upper divisor bits and MUX21H restore, with a number output.
- Banks use the existing REGP flop wrapper plus per-bank hold muxing.

Test Plan (defaults A_W=8, B_W=5, PIPE_STEP=1, L=8):
- a=200, b=7, tag=3, o_out_ready=1 -> after 8 cycles o_q=28, o_r=4, o_dz=0, o_tag=3, o_out_valid for exactly 1 cycle.
- Back-to-back (255,31), (17,1), (4,9) with ready high -> results on consecutive cycles: q=8 r=7; q=17 r=0; q=0 r=4.
- a=0xA5, b=0 -> o_q=0xFF, o_r=0x05, o_dz=1.
- Stream 12 operands with o_out_ready low -> i_in_ready drops after 8 accepts, outputs hold the first result. Raising ready drains all 12 in order, with no loss or duplication and tags matching.
- Ready toggling 1/0 each cycle with a random stream, compared against a reference model -> all results correct, in order, throughput <= 1/cycle, no bubble left while the pipe is stalled.
- rst_n pulsed low asynchronously with 5 operations in flight -> o_out_valid=0 immediately, outputs zero; a new operand after release returns only its own result at +8 cycles.
- Sweep A_W=12, B_W=6, PIPE_STEP=3, exhaustive-random 10k cases -> latency 4, all results match a/b and a%b.
